// File: rtl/ex_mem_flag_stage.sv
// rtl/ex_mem_flag_stage.sv - EX/MEM pipeline latch with NZCV flag register; optional EX_FLAG_BYPASS_EN
module ex_mem_flag_stage #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_negative,
    input  logic              ex_zero,
    input  logic              ex_carryOut,
    input  logic              ex_overflow,
    input  logic              ex_setFlags,
    input  logic [DATA_W-1:0] ex_storeData,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_regWrite,
    input  logic              ex_memRead,
    input  logic              ex_memWrite,
    input  logic              stall,
    input  logic              flush,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_result,
    output logic [DATA_W-1:0] mem_storeData,
    output logic [REG_W-1:0]  mem_rd,
    output logic              mem_regWrite,
    output logic              mem_memRead,
    output logic              mem_memWrite,
    output logic [3:0]        flags,
    output logic [3:0]        fwd_flags
);

    localparam logic [REG_W-1:0] XZR = REG_W'(31);

    logic [3:0] ex_flags;
    logic       ex_flag_write;

    assign ex_flags      = {ex_negative, ex_zero, ex_carryOut, ex_overflow};
    assign ex_flag_write = ex_valid & ex_setFlags;

    // EX/MEM latch: flush clears to a bubble, stall holds, otherwise advance qualified by ex_valid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_valid     <= 1'b0;
            mem_result    <= '0;
            mem_storeData <= '0;
            mem_rd        <= '0;
            mem_regWrite  <= 1'b0;
            mem_memRead   <= 1'b0;
            mem_memWrite  <= 1'b0;
        end else if (flush) begin
            mem_valid     <= 1'b0;
            mem_result    <= '0;
            mem_storeData <= '0;
            mem_rd        <= '0;
            mem_regWrite  <= 1'b0;
            mem_memRead   <= 1'b0;
            mem_memWrite  <= 1'b0;
        end else if (!stall) begin
            mem_valid     <= ex_valid;
            mem_result    <= ex_valid ? ex_result : '0;
            mem_storeData <= ex_valid ? ex_storeData : '0;
            mem_rd        <= ex_valid ? ex_rd : '0;
            mem_regWrite  <= ex_valid & ex_regWrite & (ex_rd != XZR);
            mem_memRead   <= ex_valid & ex_memRead;
            mem_memWrite  <= ex_valid & ex_memWrite;
        end
    end

    // Architectural NZCV: only a valid flag setter that actually advances may write it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags <= 4'b0000;
        end else if (!flush && !stall && ex_flag_write) begin
            flags <= ex_flags;
        end
    end

`ifdef EX_FLAG_BYPASS_EN
    // B.cond view includes the in-flight setter unless it is being squashed this cycle
    assign fwd_flags = (ex_flag_write && !flush) ? ex_flags : flags;
`else
    // Without bypass the hazard unit stalls B.cond until the setter has written flags
    assign fwd_flags = flags;
`endif

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// tb/tb_ex_mem_flag_stage.sv - directed self-checking bench for ex_mem_flag_stage
module tb_ex_mem_flag_stage;

    logic        clk;
    logic        reset_n;
    logic        ex_valid;
    logic [63:0] ex_result;
    logic        ex_negative, ex_zero, ex_carryOut, ex_overflow;
    logic        ex_setFlags;
    logic [63:0] ex_storeData;
    logic [4:0]  ex_rd;
    logic        ex_regWrite, ex_memRead, ex_memWrite;
    logic        stall, flush;
    logic        mem_valid;
    logic [63:0] mem_result;
    logic [63:0] mem_storeData;
    logic [4:0]  mem_rd;
    logic        mem_regWrite, mem_memRead, mem_memWrite;
    logic [3:0]  flags;
    logic [3:0]  fwd_flags;

    int tests;
    int fails;

    ex_mem_flag_stage #(.DATA_W(64), .REG_W(5)) dut (
        .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .ex_result(ex_result),
        .ex_negative(ex_negative), .ex_zero(ex_zero), .ex_carryOut(ex_carryOut),
        .ex_overflow(ex_overflow), .ex_setFlags(ex_setFlags), .ex_storeData(ex_storeData),
        .ex_rd(ex_rd), .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
        .ex_memWrite(ex_memWrite), .stall(stall), .flush(flush), .mem_valid(mem_valid),
        .mem_result(mem_result), .mem_storeData(mem_storeData), .mem_rd(mem_rd),
        .mem_regWrite(mem_regWrite), .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite),
        .flags(flags), .fwd_flags(fwd_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags_in(input logic [3:0] f);
        {ex_negative, ex_zero, ex_carryOut, ex_overflow} = f;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, {63'd0, mem_valid}, 64'd0);
        chk({tag, "_result"}, mem_result, 64'd0);
        chk({tag, "_store"}, mem_storeData, 64'd0);
        chk({tag, "_rd"}, {59'd0, mem_rd}, 64'd0);
        chk({tag, "_ctrl"}, {61'd0, mem_regWrite, mem_memRead, mem_memWrite}, 64'd0);
        chk({tag, "_flags"}, {60'd0, flags}, 64'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset_n = 1'b0;
        ex_valid = 0; ex_result = '0; ex_setFlags = 0; ex_storeData = '0; ex_rd = '0;
        ex_regWrite = 0; ex_memRead = 0; ex_memWrite = 0; stall = 0; flush = 0;
        set_flags_in(4'b0000);
        step();
        step();
        check_all_zero("reset");
        reset_n = 1'b1;

        // Advance with a flag setter; bypass visible before the edge
        ex_valid = 1; ex_result = 64'hFFFF_FFFF_FFFF_FFFE; ex_storeData = 64'h0123_4567_89AB_CDEF;
        ex_rd = 5'd3; ex_regWrite = 1; ex_memRead = 1; ex_setFlags = 1; set_flags_in(4'b1010);
        #1;
`ifdef EX_FLAG_BYPASS_EN
        chk("bypass_pre_edge", {60'd0, fwd_flags}, 64'h0000_0000_0000_000A);
`else
        chk("nobypass_pre_edge", {60'd0, fwd_flags}, 64'd0);
`endif
        step();
        chk("adv_result", mem_result, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("adv_store", mem_storeData, 64'h0123_4567_89AB_CDEF);
        chk("adv_rd", {59'd0, mem_rd}, 64'd3);
        chk("adv_regwrite", {63'd0, mem_regWrite}, 64'd1);
        chk("adv_memread", {63'd0, mem_memRead}, 64'd1);
        chk("adv_valid", {63'd0, mem_valid}, 64'd1);
        chk("adv_flags", {60'd0, flags}, 64'hA);

        // Write to XZR is suppressed
        ex_rd = 5'd31; ex_regWrite = 1; ex_memRead = 0; ex_setFlags = 0; set_flags_in(4'b0001);
        step();
        chk("xzr_regwrite", {63'd0, mem_regWrite}, 64'd0);
        chk("xzr_valid", {63'd0, mem_valid}, 64'd1);
        chk("xzr_rd", {59'd0, mem_rd}, 64'd31);
        chk("xzr_flags_hold", {60'd0, flags}, 64'hA);

        // Bubble: controls qualified, payload zeroed, flags not written
        ex_valid = 0; ex_memWrite = 1; ex_result = 64'hDEAD_BEEF_0000_1234; ex_setFlags = 1;
        step();
        chk("bubble_memwrite", {63'd0, mem_memWrite}, 64'd0);
        chk("bubble_result", mem_result, 64'd0);
        chk("bubble_valid", {63'd0, mem_valid}, 64'd0);
        chk("bubble_flags", {60'd0, flags}, 64'hA);
        chk("bubble_fwd", {60'd0, fwd_flags}, 64'hA);

        // Re-establish flags=1010, mem_rd=3
        ex_valid = 1; ex_memWrite = 0; ex_result = 64'hFFFF_FFFF_FFFF_FFFE; ex_rd = 5'd3;
        ex_setFlags = 1; set_flags_in(4'b1010);
        step();

        // Stall for three edges while EX presents a Z setter
        ex_result = 64'd5; ex_rd = 5'd7; ex_setFlags = 1; set_flags_in(4'b0100); stall = 1;
        #1;
`ifdef EX_FLAG_BYPASS_EN
        chk("stall_fwd", {60'd0, fwd_flags}, 64'h4);
`else
        chk("stall_fwd", {60'd0, fwd_flags}, 64'hA);
`endif
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_rd", {59'd0, mem_rd}, 64'd3);
            chk("stall_result", mem_result, 64'hFFFF_FFFF_FFFF_FFFE);
            chk("stall_flags", {60'd0, flags}, 64'hA);
        end
        stall = 0;
        step();
        chk("release_flags", {60'd0, flags}, 64'h4);
        chk("release_rd", {59'd0, mem_rd}, 64'd7);
        chk("release_result", mem_result, 64'd5);

        // Flush wins over stall; setter squashed
        stall = 1; flush = 1; ex_setFlags = 1; ex_memWrite = 1; set_flags_in(4'b1000);
        #1;
        chk("flush_fwd", {60'd0, fwd_flags}, 64'h4);
        step();
        chk("flush_valid", {63'd0, mem_valid}, 64'd0);
        chk("flush_memwrite", {63'd0, mem_memWrite}, 64'd0);
        chk("flush_result", mem_result, 64'd0);
        chk("flush_rd", {59'd0, mem_rd}, 64'd0);
        chk("flush_flags", {60'd0, flags}, 64'h4);

        // Back-to-back setters, last wins
        stall = 0; flush = 0; ex_memWrite = 0; set_flags_in(4'b0011);
        step();
        chk("b2b_first", {60'd0, flags}, 64'h3);
        set_flags_in(4'b0110);
        step();
        chk("b2b_second", {60'd0, flags}, 64'h6);
        chk("b2b_valid", {63'd0, mem_valid}, 64'd1);

        // Asynchronous reset mid-cycle, away from any edge
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        chk("async_reset_fwd", {60'd0, fwd_flags & {4{~(ex_valid & ex_setFlags)}}}, 64'd0);
        step();
        check_all_zero("reset_held");
        #2;
        reset_n = 1'b1;
        ex_setFlags = 0;
        step();
        chk("post_reset_valid", {63'd0, mem_valid}, 64'd1);
        chk("post_reset_flags", {60'd0, flags}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
